// File: rtl/uart_rx.sv
// uart_rx: oversampling-free UART receiver, mid-bit sampling, 8N1/8N2 style frames.
// Line input is double-synchronized; valid / frame_err are single-cycle pulses.
module uart_rx #(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_busy,
    output logic                    uart_rx_valid,
    output logic                    uart_rx_frame_err,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data
);
    localparam int CPB  = CLK_HZ / BIT_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = 1 + $clog2(CPB);
    localparam int BW   = $clog2(PAYLOAD_BITS + STOP_BITS + 1);

    typedef enum logic [1:0] {IDLE, START, RECV, STOP} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BW-1:0]           bits_q, bits_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                    err_q, err_d, valid_q, valid_d, ferr_q, ferr_d;
    logic [1:0]              sync_q;
    logic                    prev_q;
    logic                    rxd_s, fall, bit_end, stop_bad;

    assign rxd_s    = sync_q[1];
    assign fall     = prev_q & ~rxd_s;
    assign bit_end  = cnt_q == CW'(CPB - 1);
    assign stop_bad = err_q | ~rxd_s;

    assign uart_rx_busy      = state_q != IDLE;
    assign uart_rx_valid     = valid_q;
    assign uart_rx_frame_err = ferr_q;
    assign uart_rx_data      = data_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bits_d  = bits_q;
        shift_d = shift_q;
        err_d   = err_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                bits_d = '0;
                err_d  = 1'b0;
                if (fall && uart_rx_en) state_d = START;
            end
            START: if (cnt_q == CW'(HALF - 1)) begin
                cnt_d   = '0;
                state_d = rxd_s ? IDLE : RECV;
            end
            RECV: if (bit_end) begin
                cnt_d   = '0;
                shift_d = {rxd_s, shift_q[PAYLOAD_BITS-1:1]};
                bits_d  = (bits_q == BW'(PAYLOAD_BITS - 1)) ? '0 : bits_q + BW'(1);
                state_d = (bits_q == BW'(PAYLOAD_BITS - 1)) ? STOP : RECV;
            end
            default: if (bit_end) begin
                cnt_d  = '0;
                err_d  = stop_bad;
                bits_d = bits_q + BW'(1);
                if (bits_q == BW'(STOP_BITS - 1)) begin
                    state_d = IDLE;
                    valid_d = ~stop_bad;
                    ferr_d  = stop_bad;
                    data_d  = stop_bad ? data_q : shift_q;
                end
            end
        endcase
    end

    // Edge detector and synchronizer run in every state so a start edge is never missed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
            shift_q <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            err_q   <= err_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            sync_q  <= {sync_q[0], uart_rxd};
            prev_q  <= rxd_s;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at a scaled bit rate (64 clocks per bit).
// Stimulus pushes expected pulses; a negedge monitor pops and compares them.
module tb_uart_rx;
    localparam int CPB = 64;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       en = 1'b1;
    logic       busy, valid, ferr;
    logic [7:0] data;

    exp_t       sb[$];
    logic [7:0] last_good = 8'h00;
    int         vectors = 0;
    int         miscompares = 0;

    uart_rx #(
        .BIT_RATE(100_000),
        .CLK_HZ(6_400_000),
        .PAYLOAD_BITS(8),
        .STOP_BITS(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .uart_rxd(rxd),
        .uart_rx_en(en),
        .uart_rx_busy(busy),
        .uart_rx_valid(valid),
        .uart_rx_frame_err(ferr),
        .uart_rx_data(data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] need);
        vectors++;
        if (got !== need) begin
            miscompares++;
            $display("FAIL %s: got %02h, need %02h", name, got, need);
        end
    endtask

    task automatic drive(input logic v, input int cyc);
        rxd = v;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input int cyc);
        exp_t e;
        e.err  = ~stop;
        e.data = stop ? d : last_good;
        if (stop) last_good = d;
        sb.push_back(e);
        drive(1'b0, cyc);
        for (int i = 0; i < 8; i++) drive(d[i], cyc);
        drive(stop, cyc);
    endtask

    always @(negedge clk) begin
        if (!reset && (valid || ferr)) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: got valid=%0b err=%0b data=%02h, need no pulse",
                         valid, ferr, data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (valid === e.err || ferr !== e.err || data !== e.data) begin
                    miscompares++;
                    $display("FAIL frame: got valid=%0b err=%0b data=%02h, need err=%0b data=%02h",
                             valid, ferr, data, e.err, e.data);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_data", data, 8'h00);
        check("reset_valid", {7'd0, valid}, 8'h00);
        check("reset_ferr", {7'd0, ferr}, 8'h00);
        check("reset_busy", {7'd0, busy}, 8'h00);
        reset = 1'b0;
        drive(1'b1, 2 * CPB);
        send(8'hA5, 1'b1, CPB);
        drive(1'b1, 2 * CPB);
        check("data_a5", data, 8'hA5);
        send(8'h00, 1'b1, CPB);
        send(8'hFF, 1'b1, CPB);
        send(8'h3C, 1'b1, CPB);
        send(8'h55, 1'b0, CPB);
        drive(1'b0, 10 * CPB);
        check("break_busy", {7'd0, busy}, 8'h00);
        check("break_data_kept", data, 8'h3C);
        drive(1'b0, 10 * CPB);
        drive(1'b1, 2 * CPB);
        send(8'h12, 1'b1, CPB);
        drive(1'b1, 2 * CPB);
        rxd = 1'b0;
        repeat (6) @(negedge clk);
        check("glitch_busy_high", {7'd0, busy}, 8'h01);
        repeat (6) @(negedge clk);
        drive(1'b1, CPB);
        check("glitch_busy_low", {7'd0, busy}, 8'h00);
        check("glitch_data_kept", data, 8'h12);
        drive(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive(i == 0 || i == 7, CPB);
        drive(1'b0, CPB / 2);
        reset = 1'b1;
        #1;
        check("async_reset_busy", {7'd0, busy}, 8'h00);
        check("async_reset_data", data, 8'h00);
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 2 * CPB);
        send(8'h7E, 1'b1, CPB);
        drive(1'b1, 2 * CPB);
        send(8'hC3, 1'b1, CPB - 2);
        drive(1'b1, 2 * CPB);
        send(8'hC3, 1'b1, CPB + 2);
        for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
        check("pending_frames", 8'(sb.size()), 8'h00);
        check("final_data", data, 8'hC3);
        check("final_busy", {7'd0, busy}, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
